// File: rtl/xpb_pkg.sv
// Shared types and sizing for the xpb accumulator slice.
// Optional carry-save accumulation is selected with XPB_ACCUM_CSA_EN.
package xpb_pkg;

  localparam int XPB_W     = 1024;
  localparam int IDX_W     = 5;
  localparam int MAX_TERMS = 32;

  // Accumulator width: one xpb term plus enough headroom for MAX_TERMS terms.
  function automatic int acc_w(input int xpb_w, input int max_terms);
    return xpb_w + $clog2(max_terms);
  endfunction

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_RES = 2'd1,
    S_OUT = 2'd2
  } xpb_state_e;

endpackage

// File: rtl/xpb_csa_3to2.sv
// Bitwise 3:2 compressor; the carry vector is returned already shifted by one
// so that sum + carry == a + b + c modulo 2^W.
module xpb_csa_3to2 #(
  parameter int W = 1029
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = a ^ b ^ c;

  // The majority of the top bit would land above W and is dropped (mod 2^W).
  assign carry[0]   = 1'b0;
  assign carry[W-1:1] = (a[W-2:0] & b[W-2:0]) |
                        (a[W-2:0] & c[W-2:0]) |
                        (b[W-2:0] & c[W-2:0]);

endmodule

// File: rtl/xpb_accum.sv
// Consumer of an xpb lookup ROM: issues indices, sums the returned terms and
// hands the sum downstream. XPB_ACCUM_CSA_EN selects carry-save accumulation.
//
// state | meaning
// S_ACC | accepting indices and adding terms
// S_RES | resolving carry-save pair into one value (XPB_ACCUM_CSA_EN only)
// S_OUT | sum_out valid, waiting for sum_ready
module xpb_accum #(
  parameter int XPB_W     = xpb_pkg::XPB_W,
  parameter int IDX_W     = xpb_pkg::IDX_W,
  parameter int MAX_TERMS = xpb_pkg::MAX_TERMS
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          idx_valid,
  input  logic                                          idx_last,
  input  logic [IDX_W-1:0]                              idx_in,
  output logic                                          idx_ready,
  output logic [IDX_W-1:0]                              rom_idx,
  input  logic [XPB_W-1:0]                              xpb_data,
  output logic                                          sum_valid,
  input  logic                                          sum_ready,
  output logic [xpb_pkg::acc_w(XPB_W, MAX_TERMS)-1:0]   sum_out,
  output logic                                          sum_ovf
);

  import xpb_pkg::*;

  localparam int ACC_W = acc_w(XPB_W, MAX_TERMS);
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;

  xpb_state_e        state;
  logic              term_v;
  logic              term_last;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              accept;
  logic              first_term;
  logic              cnt_full;
  logic [ACC_W-1:0]  term_ext;

  // A pending last term blocks new indices so the next sum cannot start early.
  assign idx_ready  = (state == S_ACC) & ~(term_v & term_last);
  assign accept     = idx_valid & idx_ready;
  assign rom_idx    = idx_in;
  assign first_term = (cnt == '0);
  assign cnt_full   = (cnt == CNT_W'(MAX_TERMS));
  assign term_ext   = {{(ACC_W-XPB_W){1'b0}}, xpb_data};
  assign sum_ovf    = ovf;

`ifdef XPB_ACCUM_CSA_EN

  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] acc_c;
  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_c;

  xpb_csa_3to2 #(.W(ACC_W)) u_csa (
    .a     (acc_s),
    .b     (acc_c),
    .c     (term_ext),
    .sum   (csa_s),
    .carry (csa_c)
  );

  assign sum_out = acc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      term_v    <= 1'b0;
      term_last <= 1'b0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_s     <= '0;
      acc_c     <= '0;
      sum_valid <= 1'b0;
    end else begin
      term_v    <= accept;
      term_last <= accept & idx_last;
      case (state)
        S_ACC: begin
          if (term_v) begin
            if (first_term) begin
              acc_s <= term_ext;
              acc_c <= '0;
            end else begin
              acc_s <= csa_s;
              acc_c <= csa_c;
            end
            if (cnt_full) ovf <= 1'b1;
            else          cnt <= cnt + 1'b1;
            if (term_last) state <= S_RES;
          end
        end
        S_RES: begin
          acc_s     <= acc_s + acc_c;
          acc_c     <= '0;
          state     <= S_OUT;
          sum_valid <= 1'b1;
        end
        S_OUT: begin
          if (sum_ready) begin
            state     <= S_ACC;
            sum_valid <= 1'b0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state     <= S_ACC;
          sum_valid <= 1'b0;
        end
      endcase
    end
  end

`else

  logic [ACC_W-1:0] acc;

  assign sum_out = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      term_v    <= 1'b0;
      term_last <= 1'b0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      sum_valid <= 1'b0;
    end else begin
      term_v    <= accept;
      term_last <= accept & idx_last;
      case (state)
        S_ACC: begin
          if (term_v) begin
            if (first_term) acc <= term_ext;
            else            acc <= acc + term_ext;
            if (cnt_full) ovf <= 1'b1;
            else          cnt <= cnt + 1'b1;
            if (term_last) begin
              state     <= S_OUT;
              sum_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (sum_ready) begin
            state     <= S_ACC;
            sum_valid <= 1'b0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state     <= S_ACC;
          sum_valid <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_xpb_accum.sv
// Directed bench for xpb_accum with a behavioural 1-cycle ROM.
// Latency expectations follow XPB_ACCUM_CSA_EN.
module tb_xpb_accum;
  import xpb_pkg::*;

  localparam int ACC_W = acc_w(XPB_W, MAX_TERMS);
`ifdef XPB_ACCUM_CSA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             idx_valid = 1'b0;
  logic             idx_last = 1'b0;
  logic [IDX_W-1:0] idx_in = '0;
  logic             idx_ready;
  logic [IDX_W-1:0] rom_idx;
  logic [XPB_W-1:0] xpb_data;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic [ACC_W-1:0] sum_out;
  logic             sum_ovf;

  logic [XPB_W-1:0] rom [32];
  logic [ACC_W-1:0] got_sum [$];
  logic             got_ovf [$];
  int               cyc = 0;
  int               n_vec = 0;
  int               n_err = 0;
  bit               rnd_ready = 1'b0;

  xpb_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_valid (idx_valid),
    .idx_last  (idx_last),
    .idx_in    (idx_in),
    .idx_ready (idx_ready),
    .rom_idx   (rom_idx),
    .xpb_data  (xpb_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_out   (sum_out),
    .sum_ovf   (sum_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) xpb_data <= rom[rom_idx];

  always @(negedge clk)
    if (rst_n && sum_valid && sum_ready) begin
      got_sum.push_back(sum_out);
      got_ovf.push_back(sum_ovf);
    end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input bit last, output int t_acc);
    idx_valid = 1'b1;
    idx_in    = idx[IDX_W-1:0];
    idx_last  = last;
    t_acc     = cyc;
    for (int k = 0; k < 300; k++) begin
      if (rnd_ready) sum_ready = ($urandom_range(0, 2) != 0);
      #0;
      if (idx_ready) begin
        t_acc = cyc;
        tick();
        idx_valid = 1'b0;
        idx_last  = 1'b0;
        return;
      end
      tick();
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout idx=%0d idx_ready=%b", idx, idx_ready);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
  endtask

  task automatic wait_valid(output int t_v);
    for (int k = 0; k < 200; k++) begin
      if (sum_valid) begin
        t_v = cyc;
        return;
      end
      tick();
    end
    t_v = cyc;
    n_vec++; n_err++;
    $display("FAIL sum_valid_timeout sum_valid=%b", sum_valid);
  endtask

  task automatic take();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idx_in = 5'd9;
    tick(); tick();
    n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid got %b want 0", sum_valid); end
    n_vec++; if (sum_ovf !== 1'b0) begin n_err++; $display("FAIL reset_sum_ovf got %b want 0", sum_ovf); end
    n_vec++; if (sum_out !== '0) begin n_err++; $display("FAIL reset_sum_out got %h want 0", sum_out[63:0]); end
    n_vec++; if (rom_idx !== 5'd9) begin n_err++; $display("FAIL rom_idx_pass got %0d want 9", rom_idx); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (idx_ready !== 1'b1) begin n_err++; $display("FAIL reset_idx_ready got %b want 1", idx_ready); end
  endtask

  task automatic test_basic();
    int t, tv;
    send(0, 1'b0, t);
    send(0, 1'b0, t);
    send(0, 1'b1, t);
    wait_valid(tv);
    n_vec++; if (tv - t != LAT) begin n_err++; $display("FAIL basic_latency got %0d want %0d", tv - t, LAT); end
    n_vec++; if (sum_out !== ACC_W'(3)) begin n_err++; $display("FAIL basic_sum got %h_%h want 3", sum_out[ACC_W-1-:8], sum_out[63:0]); end
    n_vec++; if (sum_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", sum_ovf); end
    n_vec++; if (idx_ready !== 1'b0) begin n_err++; $display("FAIL basic_idx_ready_out got %b want 0", idx_ready); end
    take();
    n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %b want 0", sum_valid); end
  endtask

  task automatic test_ovf();
    int t, tv;
    logic [ACC_W-1:0] e;
    for (int i = 0; i < 32; i++) send(1, i == 31, t);
    wait_valid(tv);
    e = '1;
    e = e - ACC_W'(31);
    n_vec++; if (sum_out !== e) begin n_err++; $display("FAIL ovf32_sum got %h_%h want %h_%h", sum_out[ACC_W-1-:8], sum_out[63:0], e[ACC_W-1-:8], e[63:0]); end
    n_vec++; if (sum_ovf !== 1'b0) begin n_err++; $display("FAIL ovf32_flag got %b want 0", sum_ovf); end
    take();
    for (int i = 0; i < 33; i++) send(1, i == 32, t);
    wait_valid(tv);
    e = '0;
    e[XPB_W] = 1'b1;
    e = e - ACC_W'(33);
    n_vec++; if (sum_out !== e) begin n_err++; $display("FAIL ovf33_sum got %h_%h want %h_%h", sum_out[ACC_W-1-:8], sum_out[63:0], e[ACC_W-1-:8], e[63:0]); end
    n_vec++; if (sum_ovf !== 1'b1) begin n_err++; $display("FAIL ovf33_flag got %b want 1", sum_ovf); end
    take();
    n_vec++; if (sum_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", sum_ovf); end
  endtask

  task automatic test_stall();
    int t, tv;
    logic [ACC_W-1:0] e;
    send(2, 1'b0, t);
    send(3, 1'b1, t);
    wait_valid(tv);
    idx_valid = 1'b1;
    idx_in    = 5'd4;
    idx_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (idx_ready !== 1'b0) begin n_err++; $display("FAIL stall_idx_ready c%0d got %b want 0", i, idx_ready); end
      n_vec++; if (sum_out !== ACC_W'(12) || sum_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold c%0d got %h v=%b want 12 v=1", i, sum_out[63:0], sum_valid); end
      tick();
    end
    take();
    n_vec++; if (idx_ready !== 1'b1) begin n_err++; $display("FAIL stall_restart_ready got %b want 1", idx_ready); end
    tick();
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    wait_valid(tv);
    e = {{(ACC_W-XPB_W){1'b0}}, rom[4]};
    n_vec++; if (sum_out !== e) begin n_err++; $display("FAIL stall_clean_start got %h want %h", sum_out[63:0], e[63:0]); end
    take();
  endtask

  task automatic test_back_to_back();
    int t;
    logic [ACC_W-1:0] e0, e1, e2;
    got_sum.delete();
    got_ovf.delete();
    sum_ready = 1'b1;
    send(3, 1'b1, t);
    send(2, 1'b0, t);
    send(3, 1'b1, t);
    send(5, 1'b1, t);
    for (int k = 0; k < 50 && got_sum.size() < 3; k++) tick();
    sum_ready = 1'b0;
    n_vec++;
    if (got_sum.size() != 3) begin
      n_err++; $display("FAIL b2b_count got %0d want 3", got_sum.size());
    end else begin
      e0 = ACC_W'(7);
      e1 = ACC_W'(12);
      e2 = {{(ACC_W-XPB_W){1'b0}}, rom[5]};
      if (got_sum[0] !== e0) begin n_err++; $display("FAIL b2b_sum0 got %h want %h", got_sum[0][63:0], e0[63:0]); end
      n_vec++; if (got_sum[1] !== e1) begin n_err++; $display("FAIL b2b_sum1 got %h want %h", got_sum[1][63:0], e1[63:0]); end
      n_vec++; if (got_sum[2] !== e2) begin n_err++; $display("FAIL b2b_sum2 got %h want %h", got_sum[2][63:0], e2[63:0]); end
    end
  endtask

  task automatic test_async_reset();
    int t, tv;
    send(1, 1'b1, t);
    wait_valid(tv);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", sum_valid); end
    n_vec++; if (sum_out !== '0) begin n_err++; $display("FAIL areset_sum got %h want 0", sum_out[63:0]); end
    #10 rst_n = 1'b1;
    tick();
    send(3, 1'b0, t);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    send(2, 1'b0, t);
    send(3, 1'b1, t);
    wait_valid(tv);
    n_vec++; if (sum_out !== ACC_W'(12)) begin n_err++; $display("FAIL areset_new_sum got %h want 12", sum_out[63:0]); end
    n_vec++; if (sum_ovf !== 1'b0) begin n_err++; $display("FAIL areset_new_ovf got %b want 0", sum_ovf); end
    take();
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] exp_s [$];
    bit               exp_o [$];
    logic [ACC_W-1:0] acc;
    int               len, idx, t;
    got_sum.delete();
    got_ovf.delete();
    rnd_ready = 1'b1;
    for (int s = 0; s < 14; s++) begin
      len = (s == 7) ? 34 : $urandom_range(1, 6);
      acc = '0;
      for (int i = 0; i < len; i++) begin
        idx = $urandom_range(0, 31);
        acc = acc + {{(ACC_W-XPB_W){1'b0}}, rom[idx]};
        if ($urandom_range(0, 3) == 0) begin
          sum_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        send(idx, i == len - 1, t);
      end
      exp_s.push_back(acc);
      exp_o.push_back(len > MAX_TERMS);
    end
    rnd_ready = 1'b0;
    sum_ready = 1'b1;
    for (int k = 0; k < 200 && got_sum.size() < exp_s.size(); k++) tick();
    sum_ready = 1'b0;
    n_vec++;
    if (got_sum.size() != exp_s.size()) begin
      n_err++; $display("FAIL rand_count got %0d want %0d", got_sum.size(), exp_s.size());
    end else begin
      foreach (exp_s[i]) begin
        n_vec++;
        if (got_sum[i] !== exp_s[i] || got_ovf[i] !== exp_o[i]) begin
          n_err++;
          $display("FAIL rand_sum%0d got %h_%h o=%b want %h_%h o=%b", i, got_sum[i][ACC_W-1-:8], got_sum[i][63:0], got_ovf[i], exp_s[i][ACC_W-1-:8], exp_s[i][63:0], exp_o[i]);
        end
      end
    end
  endtask

  initial begin
    rom[0] = '0; rom[0][0] = 1'b1;
    rom[1] = '1;
    rom[2] = '0; rom[2][2:0] = 3'd5;
    rom[3] = '0; rom[3][2:0] = 3'd7;
    for (int i = 4; i < 32; i++)
      for (int j = 0; j < 32; j++)
        rom[i][j*32 +: 32] = $urandom;
    test_reset();
    test_basic();
    test_ovf();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
